// File: rtl/inv_rotate_unit.sv
// inv_rotate_unit: inverse Keccak rho step over a 64-slice x 25-lane frame.
// Destination slice z, lane l = source slice (z + r[l]) mod 64, lane l.
// The source is read one lane at a time and each destination slice is
// written whole.
// Build option: define INV_ROTATE_PIPE_EN to overlap the reads and the
// captures, giving 28 cycles per slice instead of 52. Undefined (the
// default) gives the one-read-then-one-capture sequence.
//
// Handshake: there is no back-pressure. rd_en, wr_en and ready are each
// high for exactly one cycle per event. rd_data must be valid in the cycle
// after rd_en. rd_addr, wr_addr and wr_data keep their last values while
// their strobe is low.
module inv_rotate_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        rd_en,
  output logic [5:0]  rd_addr,
  input  logic [24:0] rd_data,
  output logic        wr_en,
  output logic [5:0]  wr_addr,
  output logic [24:0] wr_data,
  output logic        busy,
  output logic        ready,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    SLICE = 3'd2,
    RD    = 3'd3,
    CAP   = 3'd4,
    WR    = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t      state;
  logic [5:0]  z;
  logic [4:0]  l;
  logic [24:0] collect;
  logic [24:0] collect_cap;
  logic [4:0]  cap_idx;

  // Rho rotation offsets, one per lane l = x + 5y.
  function automatic logic [5:0] rho_off(input logic [4:0] lane);
    logic [5:0] r;
    case (lane)
      5'd0:  r = 6'd0;
      5'd1:  r = 6'd1;
      5'd2:  r = 6'd62;
      5'd3:  r = 6'd28;
      5'd4:  r = 6'd27;
      5'd5:  r = 6'd36;
      5'd6:  r = 6'd44;
      5'd7:  r = 6'd6;
      5'd8:  r = 6'd55;
      5'd9:  r = 6'd20;
      5'd10: r = 6'd3;
      5'd11: r = 6'd10;
      5'd12: r = 6'd43;
      5'd13: r = 6'd25;
      5'd14: r = 6'd39;
      5'd15: r = 6'd41;
      5'd16: r = 6'd45;
      5'd17: r = 6'd15;
      5'd18: r = 6'd21;
      5'd19: r = 6'd8;
      5'd20: r = 6'd18;
      5'd21: r = 6'd2;
      5'd22: r = 6'd61;
      5'd23: r = 6'd56;
      5'd24: r = 6'd14;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  // Strobes and status come straight from the current state.
  assign rd_en     = (state == RD);
  assign wr_en     = (state == WR);
  assign ready     = (state == DONE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Collect register with the returning read merged into the lane it
  // belongs to. In the overlapped build, data arriving during RD belongs to
  // the previous lane. At l=0 the index wraps to 31, which matches no lane,
  // so nothing is merged.
  always_comb begin
    cap_idx = l;
`ifdef INV_ROTATE_PIPE_EN
    if (state == RD) cap_idx = l - 5'd1;
`endif
    collect_cap = collect;
    for (int i = 0; i < 25; i++) begin
      if (cap_idx == 5'(i)) collect_cap[i] = rd_data[i];
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      z       <= 6'd0;
      l       <= 5'd0;
      collect <= 25'd0;
      rd_addr <= 6'd0;
      wr_addr <= 6'd0;
      wr_data <= 25'd0;
    end else begin
      case (state)
        IDLE: if (start) state <= ARM;
        ARM: begin
          if (!start) begin
            z     <= 6'd0;
            state <= SLICE;
          end
        end
        SLICE: begin
          collect <= 25'd0;
          l       <= 5'd0;
          rd_addr <= z + rho_off(5'd0);
          state   <= RD;
        end
        RD: begin
`ifdef INV_ROTATE_PIPE_EN
          collect <= collect_cap;
          if (l == 5'd24) begin
            state <= CAP;
          end else begin
            l       <= l + 5'd1;
            rd_addr <= z + rho_off(l + 5'd1);
          end
`else
          state <= CAP;
`endif
        end
        CAP: begin
          // In the overlapped build CAP is only reached with l=24, where
          // it acts as the drain cycle for the last lane.
          collect <= collect_cap;
          if (l == 5'd24) begin
            wr_addr <= z;
            wr_data <= collect_cap;
            state   <= WR;
          end else begin
            l       <= l + 5'd1;
            rd_addr <= z + rho_off(l + 5'd1);
            state   <= RD;
          end
        end
        WR: begin
          if (z == 6'd63) begin
            state <= DONE;
          end else begin
            z     <= z + 6'd1;
            state <= SLICE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_rotate_unit.sv
// tb_inv_rotate_unit: self-checking bench for inv_rotate_unit. A source
// frame memory answers reads one cycle after rd_en, and a negedge monitor
// logs reads, writes and the ready pulse. Results are checked against a
// table-driven rho model. Latency constants follow INV_ROTATE_PIPE_EN.
module tb_inv_rotate_unit;

`ifdef INV_ROTATE_PIPE_EN
  localparam int SLICE_CYC = 28;
`else
  localparam int SLICE_CYC = 52;
`endif
  localparam int OP_CYC = 64 * SLICE_CYC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [24:0] rd_data = 25'd0;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [24:0] wr_data;
  logic        busy;
  logic        ready;
  logic [2:0]  state_dbg;

  inv_rotate_unit dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .ready(ready), .state_dbg(state_dbg)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rtab[25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                   41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  logic [24:0] src_mem[64];
  logic [24:0] dst_mem[64];
  logic [24:0] exp_q[$];
  logic [5:0]  rd_trace[$];
  logic [5:0]  wr_z_q[$];
  logic [24:0] wr_d_q[$];
  int rd_count, wr_count, ready_count, first_rd_cyc, ready_cyc, start_fall_cyc;
  int pass_cnt = 0;
  int total_cnt = 0;

  // Source frame memory: registered read, one cycle of latency.
  always @(posedge clk) if (rd_en) rd_data <= src_mem[rd_addr];

  // Monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rd_en) begin
      if (rd_count == 0) first_rd_cyc = cyc;
      rd_trace.push_back(rd_addr);
      rd_count++;
    end
    if (wr_en) begin
      wr_z_q.push_back(wr_addr);
      wr_d_q.push_back(wr_data);
      wr_count++;
    end
    if (ready) begin
      ready_count++;
      ready_cyc = cyc;
    end
  end

  // Reference: dest slice z, lane l comes from source slice (z + r[l]) mod 64.
  function automatic logic [24:0] ref_slice(input int z);
    logic [24:0] s;
    logic [24:0] w;
    s = '0;
    for (int ln = 0; ln < 25; ln++) begin
      w = src_mem[(z + rtab[ln]) % 64];
      s[ln] = w[ln];
    end
    return s;
  endfunction

  task automatic clear_mon();
    rd_count = 0; wr_count = 0; ready_count = 0;
    first_rd_cyc = -1; ready_cyc = -1;
    rd_trace.delete(); wr_z_q.delete(); wr_d_q.delete(); exp_q.delete();
  endtask

  task automatic start_op(input int hold);
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    start = 1'b0;
    start_fall_cyc = cyc;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < OP_CYC + 500; i++) begin
      @(negedge clk);
      if (ready_count > 0) begin
        ok = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (!ok) $display("FAIL %s timeout: ready seen %0d, required 1", name, ready_count);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_op(input string name);
    logic [24:0] e;
    logic [24:0] gd;
    logic [5:0]  gz;
    total_cnt++;
    if (rd_count !== 1600) $display("FAIL %s reads: got %0d want 1600", name, rd_count);
    else pass_cnt++;
    total_cnt++;
    if (wr_count !== 64) $display("FAIL %s writes: got %0d want 64", name, wr_count);
    else pass_cnt++;
    total_cnt++;
    if (ready_count !== 1) $display("FAIL %s ready pulses: got %0d want 1", name, ready_count);
    else pass_cnt++;
    total_cnt++;
    if (first_rd_cyc !== start_fall_cyc + 2)
      $display("FAIL %s first rd: got cycle %0d want %0d", name, first_rd_cyc, start_fall_cyc + 2);
    else pass_cnt++;
    total_cnt++;
    if (ready_cyc - (first_rd_cyc - 1) !== OP_CYC)
      $display("FAIL %s latency: got %0d want %0d", name, ready_cyc - (first_rd_cyc - 1), OP_CYC);
    else pass_cnt++;
    for (int z = 0; z < 64; z++) exp_q.push_back(ref_slice(z));
    for (int i = 0; i < 64; i++) begin
      e  = exp_q.pop_front();
      gd = (i < wr_d_q.size()) ? wr_d_q[i] : 25'bx;
      gz = (i < wr_z_q.size()) ? wr_z_q[i] : 6'bx;
      dst_mem[i] = gd;
      total_cnt++;
      if (gz !== 6'(i) || gd !== e)
        $display("FAIL %s write %0d: got addr %0d data %h want addr %0d data %h",
                 name, i, gz, gd, i, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({rd_en, wr_en, ready, busy} !== 4'b0000)
      $display("FAIL reset outputs: got rd %b wr %b ready %b busy %b want all 0", rd_en, wr_en, ready, busy);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL idle busy: got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_zero_source();
    for (int i = 0; i < 64; i++) src_mem[i] = 25'd0;
    start_op(1);
    wait_done("zero");
    check_op("zero");
  endtask

  task automatic test_single_slice();
    for (int i = 0; i < 64; i++) src_mem[i] = 25'd0;
    src_mem[5] = 25'h1FFFFFF;
    start_op($urandom_range(1, 4));
    wait_done("slice5");
    check_op("slice5");
    total_cnt++;
    if ({dst_mem[5][0], dst_mem[4][1], dst_mem[7][2]} !== 3'b111)
      $display("FAIL slice5 bits: got %b%b%b want 111", dst_mem[5][0], dst_mem[4][1], dst_mem[7][2]);
    else pass_cnt++;
  endtask

  task automatic test_random_roundtrip();
    logic [24:0] fwd;
    logic [24:0] w;
    for (int i = 0; i < 64; i++) src_mem[i] = 25'($urandom);
    start_op($urandom_range(1, 6));
    wait_done("random");
    check_op("random");
    // Forward rho on the captured result must give the source back.
    for (int z = 0; z < 64; z++) begin
      fwd = '0;
      for (int ln = 0; ln < 25; ln++) begin
        w = dst_mem[(z - rtab[ln] + 64) % 64];
        fwd[ln] = w[ln];
      end
      total_cnt++;
      if (fwd !== src_mem[z]) $display("FAIL roundtrip z=%0d: got %h want %h", z, fwd, src_mem[z]);
      else pass_cnt++;
    end
  endtask

  task automatic test_read_trace();
    int lanes[3] = '{2, 8, 23};
    int want[3] = '{58, 51, 52};
    logic [5:0] got;
    for (int k = 0; k < 3; k++) begin
      got = (rd_trace.size() > 60 * 25 + lanes[k]) ? rd_trace[60 * 25 + lanes[k]] : 6'bx;
      total_cnt++;
      if (got !== 6'(want[k]))
        $display("FAIL trace z=60 lane %0d: got %0d want %0d", lanes[k], got, want[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_hold();
    bit busy_ok;
    for (int i = 0; i < 64; i++) src_mem[i] = 25'($urandom);
    clear_mon();
    busy_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    total_cnt++;
    if (rd_count !== 0 || !busy_ok)
      $display("FAIL hold arm: got reads %0d busy_ok %b want reads 0 busy_ok 1", rd_count, busy_ok);
    else pass_cnt++;
    start = 1'b0;
    start_fall_cyc = cyc;
    wait_done("hold");
    check_op("hold");
  endtask

  task automatic test_abort();
    int target, rd_s, wr_s;
    for (int i = 0; i < 64; i++) src_mem[i] = 25'($urandom);
    start_op(1);
    for (int i = 0; i < 20 && rd_count == 0; i++) begin
      @(posedge clk); #1;
    end
    target = first_rd_cyc - 1 + 30 * SLICE_CYC + 9;
    for (int i = 0; i < OP_CYC && cyc < target; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({busy, ready, rd_en, wr_en} !== 4'b0000)
      $display("FAIL abort outputs: got busy %b ready %b rd %b wr %b want all 0", busy, ready, rd_en, wr_en);
    else pass_cnt++;
    @(posedge clk); #1;
    rd_s = rd_count;
    wr_s = wr_count;
    total_cnt++;
    if (wr_s !== 30) $display("FAIL abort writes before: got %0d want 30", wr_s);
    else pass_cnt++;
    rst = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    total_cnt++;
    if (rd_count !== rd_s || wr_count !== wr_s || ready_count !== 0)
      $display("FAIL abort quiet: got rd %0d wr %0d ready %0d want rd %0d wr %0d ready 0",
               rd_count, wr_count, ready_count, rd_s, wr_s);
    else pass_cnt++;
    start_op(2);
    wait_done("restart");
    check_op("restart");
  endtask

  initial begin
    test_reset();
    test_zero_source();
    test_single_slice();
    test_random_roundtrip();
    test_read_trace();
    test_start_hold();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/inv_rotate_unit.md
INV_ROTATE_UNIT -- requirements
Module: inv_rotate_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL update on the rising edge of clk only.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-low reset; 0 sampled at a rising edge resets the block.
REQ-004 start  input  1  level request; the operation begins when start is seen high and then low.
REQ-005 rd_en  output  1  source-frame memory read strobe.
REQ-006 rd_addr  output  6  source slice index z.
REQ-007 rd_data  input  25  source slice bits; valid exactly one cycle after rd_en.
REQ-008 wr_en  output  1  destination-frame memory write strobe.
REQ-009 wr_addr  output  6  destination slice index.
REQ-010 wr_data  output  25  destination slice bits, indexed by lane l = x+5y.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 ready  output  1  one-cycle completion pulse.

Function
REQ-013 The block SHALL compute the inverse Keccak rho step: dest slice z, bit l = source slice ((z + r[l]) mod 64), bit l.
REQ-014 The r[l] SHALL be fixed constants for l=0..24: 0,1,62,28,27,36,44,6,55,20,3,10,43,25,39,41,45,15,21,8,18,2,61,56,14.
REQ-015 Address arithmetic SHALL be 6-bit unsigned, so wrap-around past 63 is implicit (example: z=60, r=6 gives address 2).
REQ-016 The states SHALL be IDLE, ARM, SLICE, RD, CAP, WR, DONE.
REQ-017 IDLE SHALL go to ARM when start=1.
REQ-018 ARM SHALL go to SLICE when start=0, clearing the slice counter z to 0.
REQ-019 SLICE SHALL clear the 25-bit collect register and the lane counter l, then go to RD.
REQ-020 RD SHALL assert rd_en with rd_addr=(z+r[l]) mod 64, then go to CAP.
REQ-021 CAP SHALL store rd_data[l] into collect[l]; on l=24 it SHALL go to WR, otherwise it SHALL increment l and go to RD.
REQ-022 WR SHALL assert wr_en with wr_addr=z and wr_data=collect; on z=63 it SHALL go to DONE, otherwise it SHALL increment z and go to SLICE.
REQ-023 DONE SHALL assert ready for one cycle, then go to IDLE.
REQ-024 Each slice SHALL take exactly 52 cycles (1+25×2+1), and DONE SHALL be entered 3328 cycles after SLICE is first entered.
REQ-025 The outputs rd_en, wr_en and ready SHALL be decoded from the current state, and each SHALL be high for exactly one cycle per event.
REQ-026 Exactly 1600 reads and 64 writes SHALL occur per operation, with writes in ascending z order 0..63.
REQ-027 start SHALL be ignored in every state except IDLE and ARM; holding start high SHALL keep the block in ARM.
REQ-028 rd_addr, wr_addr and wr_data SHALL hold their last values when their strobe is low, and the bench SHALL NOT check them while the strobe is low.

Reset
REQ-029 While rst=0, the state SHALL be IDLE, z=0, l=0, collect=0, and rd_en, wr_en, ready and busy SHALL all be 0.
REQ-030 A reset during any state SHALL abort the operation with no further rd_en or wr_en, and the block SHALL then need a new start high-low sequence.

Configuration
REQ-031 The macro INV_ROTATE_PIPE_EN SHALL select between a pipelined and a non-pipelined read sequence.
REQ-032 With INV_ROTATE_PIPE_EN defined, RD and CAP SHALL overlap: rd_en is high for 25 consecutive cycles (l=0..24), and each rd_data is captured one cycle later.
REQ-033 In the pipelined build, one drain cycle SHALL follow before WR, giving 28 cycles per slice and DONE entered 1792 cycles after the first SLICE.
REQ-034 Without INV_ROTATE_PIPE_EN, REQ-019..REQ-024 SHALL apply unchanged.
REQ-035 Results SHALL be bit-identical in both builds.

Verification
REQ-036 Reset then start pulse with an all-zero source -> 64 writes of 0, ready pulse exactly 3328 cycles after SLICE is first entered (1792 with the macro).
REQ-037 Source slice 5 = 25'h1FFFFFF, all other slices 0 -> dest slice 5 bit0=1, dest slice 4 bit1=1, dest slice 7 bit2=1 (5-62 mod 64), every write matches the r[] table.
REQ-038 Random source, then the result fed through the team's forward rotate path -> the original source is recovered bit-exactly.
REQ-039 Read-address trace for z=60 -> lane 2 reads slice 58, lane 8 reads slice 51, lane 23 reads slice 52.
REQ-040 rst=0 asserted in the 10th cycle of slice 30 -> no writes after the abort, busy=0 and ready=0 on the next cycle, and a fresh start completes normally.
REQ-041 start held high for 100 cycles -> the block stays in ARM with rd_en=0, and the first rd_en occurs 2 cycles after start falls (SLICE then RD).
